serial_subtractor: RTL

- Bit-serial borrow-ripple subtractor: computes Diff = A - B - Bin, LSB first, one bit per clock, through a single full-subtractor cell.
- Subtraction counterpart of the combinational ripple_adder (A + B + Cin -> Sum, Cout). Same operand/carry-style interface, trades area for latency.
- Used where a multi-bit subtract is needed without W cells of ripple logic. Start/busy/done handshake toward the controlling FSM.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 97 +++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

   localparam int unsigned SUB_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial borrow-ripple subtractor: Diff = A - B - Bin, LSB first, one bit per clock.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned W = SUB_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Bin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] Diff,
   output logic         Bout
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   a_sr;
   logic [W-1:0]   b_sr;
   logic [W-1:0]   res_sr;
   logic [W-1:0]   res_next;
   logic           borrow;
   logic [CW-1:0]  count;
   logic           last_bit;
   logic           cell_d;
   logic           cell_bout;

   full_subtractor u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign last_bit = (count == CW'(W - 1));
   // New bit enters at the MSB so the LSB-first stream lands in place after W shifts.
   assign res_next = (res_sr >> 1) | (W'(cell_d) << (W - 1));

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register and serial datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         count  <= '0;
         Diff   <= '0;
         Bout   <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= A;
                  b_sr   <= B;
                  borrow <= Bin;
                  count  <= '0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               borrow <= cell_bout;
               count  <= count + CW'(1);
               if (last_bit) begin
                  Diff <= res_next;
                  Bout <= cell_bout;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule : serial_subtractor
